// File: rtl/ata_pio_device.sv
// ATA PIO device-side register interface: synchronizes the host bus, decodes
// register accesses, holds the task file and hands data-port words to the local side.
module ata_pio_device #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        RESETn,
    input  logic [15:0] DDi,
    output logic [15:0] DDo,
    output logic        DDoe,
    input  logic [2:0]  DA,
    input  logic        CS0n,
    input  logic        CS1n,
    input  logic        DIORn,
    input  logic        DIOWn,
    output logic        IORDY,
    output logic        INTRQ,
    output logic [15:0] wr_data,
    output logic        wr_stb,
    input  logic [15:0] rd_data,
    output logic        rd_stb,
    output logic        cmd_stb,
    output logic [7:0]  cmd,
    output logic [7:0]  tf_features,
    output logic [7:0]  tf_count,
    output logic [7:0]  tf_lba_lo,
    output logic [7:0]  tf_lba_mid,
    output logic [7:0]  tf_lba_hi,
    output logic [7:0]  tf_device,
    input  logic [7:0]  stat,
    input  logic [7:0]  err,
    input  logic        irq_set,
    output logic        srst,
    output logic [1:0]  state_dbg
);

    // Host handshake: an access opens on the falling edge of exactly one strobe
    // and closes on that strobe's rising edge; IORDY low asks the host to stretch
    // the strobe, and the local side only ever sees completed accesses.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t         state;
    logic [CW-1:0]  wait_cnt;

    logic [1:0] dior_sy, diow_sy, cs0_sy, cs1_sy, rst_sy;
    logic [2:0] da_sy0, da_sy1;
    logic       dior_q, diow_q;

    logic       acc_rd, acc_cmd, acc_ctl;
    logic [2:0] acc_da;
    logic [15:0] wr_sample;
    logic       pending, nien;

    logic dior_s, diow_s, cs0_s, cs1_s, rst_s;
    logic [2:0] da_s;
    logic start_rd, start_wr, start_any;
    logic sel_cmd_c, sel_ctl_c, start_data, start_mapped_rd;
    logic release_det, commit, clr_pending;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            dior_sy <= 2'b11;
            diow_sy <= 2'b11;
            cs0_sy  <= 2'b11;
            cs1_sy  <= 2'b11;
            rst_sy  <= 2'b11;
            da_sy0  <= 3'd0;
            da_sy1  <= 3'd0;
            dior_q  <= 1'b1;
            diow_q  <= 1'b1;
        end else begin
            dior_sy <= {dior_sy[0], DIORn};
            diow_sy <= {diow_sy[0], DIOWn};
            cs0_sy  <= {cs0_sy[0], CS0n};
            cs1_sy  <= {cs1_sy[0], CS1n};
            rst_sy  <= {rst_sy[0], RESETn};
            da_sy0  <= DA;
            da_sy1  <= da_sy0;
            dior_q  <= dior_sy[1];
            diow_q  <= diow_sy[1];
        end
    end

    assign dior_s = dior_sy[1];
    assign diow_s = diow_sy[1];
    assign cs0_s  = cs0_sy[1];
    assign cs1_s  = cs1_sy[1];
    assign rst_s  = rst_sy[1];
    assign da_s   = da_sy1;

    // A fall on one strobe while the other is low is not a legal access.
    assign start_rd  = dior_q & ~dior_s & diow_s;
    assign start_wr  = diow_q & ~diow_s & dior_s;
    assign start_any = start_rd | start_wr;

    assign sel_cmd_c       = ~cs0_s & cs1_s;
    assign sel_ctl_c       = cs0_s & ~cs1_s & (da_s == 3'd6);
    assign start_data      = sel_cmd_c & (da_s == 3'd0);
    assign start_mapped_rd = start_rd & (sel_cmd_c | sel_ctl_c);

    assign release_det = acc_rd ? (~dior_q & dior_s) : (~diow_q & diow_s);
    assign commit      = (state == ACTIVE) & release_det & rst_s;
    // Status read and Command write both acknowledge the interrupt.
    assign clr_pending = commit & acc_cmd & (acc_da == 3'd7);

    function automatic logic [15:0] read_mux(input logic ctl, input logic [2:0] a);
        logic [15:0] v;
        v = 16'h0000;
        if (ctl) begin
            v = {8'h00, stat};
        end else begin
            case (a)
                3'd0:    v = rd_data;
                3'd1:    v = {8'h00, err};
                3'd2:    v = {8'h00, tf_count};
                3'd3:    v = {8'h00, tf_lba_lo};
                3'd4:    v = {8'h00, tf_lba_mid};
                3'd5:    v = {8'h00, tf_lba_hi};
                3'd6:    v = {8'h00, tf_device};
                default: v = {8'h00, stat};
            endcase
        end
        return v;
    endfunction

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            DDo         <= 16'h0000;
            DDoe        <= 1'b0;
            IORDY       <= 1'b1;
            wr_stb      <= 1'b0;
            rd_stb      <= 1'b0;
            cmd_stb     <= 1'b0;
            wr_data     <= 16'h0000;
            cmd         <= 8'h00;
            tf_features <= 8'h00;
            tf_count    <= 8'h00;
            tf_lba_lo   <= 8'h00;
            tf_lba_mid  <= 8'h00;
            tf_lba_hi   <= 8'h00;
            tf_device   <= 8'h00;
            srst        <= 1'b0;
            nien        <= 1'b0;
            pending     <= 1'b0;
            acc_rd      <= 1'b0;
            acc_cmd     <= 1'b0;
            acc_ctl     <= 1'b0;
            acc_da      <= 3'd0;
            wr_sample   <= 16'h0000;
        end else begin
            wr_stb  <= 1'b0;
            rd_stb  <= 1'b0;
            cmd_stb <= 1'b0;

            if (!rst_s) begin
                state       <= IDLE;
                DDo         <= 16'h0000;
                DDoe        <= 1'b0;
                IORDY       <= 1'b1;
                cmd         <= 8'h00;
                tf_features <= 8'h00;
                tf_count    <= 8'h00;
                tf_lba_lo   <= 8'h00;
                tf_lba_mid  <= 8'h00;
                tf_lba_hi   <= 8'h00;
                tf_device   <= 8'h00;
                nien        <= 1'b0;
                pending     <= 1'b0;
            end else begin
                if (irq_set)
                    pending <= 1'b1;
                else if (clr_pending)
                    pending <= 1'b0;

                case (state)
                    IDLE: begin
                        if (start_any) begin
                            acc_rd    <= start_rd;
                            acc_cmd   <= sel_cmd_c;
                            acc_ctl   <= sel_ctl_c;
                            acc_da    <= da_s;
                            wr_sample <= DDi;
                            if (start_data && (WAIT_CYCLES > 0)) begin
                                state    <= WAIT;
                                IORDY    <= 1'b0;
                                wait_cnt <= WAIT_LOAD;
                            end else begin
                                state <= ACTIVE;
                            end
                            if (start_mapped_rd) begin
                                DDoe <= 1'b1;
                                DDo  <= read_mux(sel_ctl_c, da_s);
                            end
                        end
                    end

                    WAIT: begin
                        if (release_det) begin
                            state <= IDLE;
                            IORDY <= 1'b1;
                            DDoe  <= 1'b0;
                            DDo   <= 16'h0000;
                        end else begin
                            if (wait_cnt == '0) begin
                                state <= ACTIVE;
                                IORDY <= 1'b1;
                            end else begin
                                wait_cnt <= wait_cnt - 1'b1;
                            end
                            if (acc_rd)
                                DDo <= rd_data;
                        end
                    end

                    ACTIVE: begin
                        wr_sample <= DDi;
                        if (release_det) begin
                            state <= IDLE;
                            DDoe  <= 1'b0;
                            DDo   <= 16'h0000;
                            if (acc_rd) begin
                                if (acc_cmd && acc_da == 3'd0)
                                    rd_stb <= 1'b1;
                            end else if (acc_cmd) begin
                                case (acc_da)
                                    3'd0: begin
                                        wr_data <= wr_sample;
                                        wr_stb  <= 1'b1;
                                    end
                                    3'd1:    tf_features <= wr_sample[7:0];
                                    3'd2:    tf_count    <= wr_sample[7:0];
                                    3'd3:    tf_lba_lo   <= wr_sample[7:0];
                                    3'd4:    tf_lba_mid  <= wr_sample[7:0];
                                    3'd5:    tf_lba_hi   <= wr_sample[7:0];
                                    3'd6:    tf_device   <= wr_sample[7:0];
                                    default: begin
                                        cmd     <= wr_sample[7:0];
                                        cmd_stb <= 1'b1;
                                    end
                                endcase
                            end else if (acc_ctl) begin
                                nien <= wr_sample[1];
                                srst <= wr_sample[2];
                            end
                        end else if (acc_rd && (acc_cmd || acc_ctl)) begin
                            DDo <= read_mux(acc_ctl, acc_da);
                        end
                    end

                    default: begin
                        state <= IDLE;
                        IORDY <= 1'b1;
                        DDoe  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign INTRQ     = pending & ~nien;
    assign state_dbg = state;

endmodule

// File: tb/tb_ata_pio_device.sv
// Directed bench for ata_pio_device: instance a runs with WAIT_CYCLES=4, instance b
// with WAIT_CYCLES=0, both on the same host bus.
module tb_ata_pio_device;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        RESETn = 1'b1;
  logic [15:0] DDi = 16'h0000;
  logic [2:0]  DA = 3'd0;
  logic        CS0n = 1'b1, CS1n = 1'b1, DIORn = 1'b1, DIOWn = 1'b1;
  logic [15:0] rd_data = 16'h1234;
  logic [7:0]  stat = 8'h50, err = 8'h04;
  logic        irq_set = 1'b0;

  logic [15:0] DDo_a, DDo_b, wr_data_a, wr_data_b;
  logic        DDoe_a, DDoe_b, IORDY_a, IORDY_b, INTRQ_a, INTRQ_b;
  logic        wr_stb_a, wr_stb_b, rd_stb_a, rd_stb_b, cmd_stb_a, cmd_stb_b;
  logic [7:0]  cmd_a, cmd_b, feat_a, feat_b, cnt_a, cnt_b, llo_a, llo_b;
  logic [7:0]  lmid_a, lmid_b, lhi_a, lhi_b, dev_a, dev_b;
  logic        srst_a, srst_b;
  logic [1:0]  st_a, st_b;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_a = 0, wr_b = 0, rd_a = 0, rd_b = 0, cm_a = 0, cm_b = 0, lo_a = 0, lo_b = 0;

  ata_pio_device #(.WAIT_CYCLES(4)) dut_a (
    .clk(clk), .nReset(nReset), .RESETn(RESETn), .DDi(DDi), .DDo(DDo_a), .DDoe(DDoe_a),
    .DA(DA), .CS0n(CS0n), .CS1n(CS1n), .DIORn(DIORn), .DIOWn(DIOWn), .IORDY(IORDY_a),
    .INTRQ(INTRQ_a), .wr_data(wr_data_a), .wr_stb(wr_stb_a), .rd_data(rd_data),
    .rd_stb(rd_stb_a), .cmd_stb(cmd_stb_a), .cmd(cmd_a), .tf_features(feat_a),
    .tf_count(cnt_a), .tf_lba_lo(llo_a), .tf_lba_mid(lmid_a), .tf_lba_hi(lhi_a),
    .tf_device(dev_a), .stat(stat), .err(err), .irq_set(irq_set), .srst(srst_a),
    .state_dbg(st_a)
  );

  ata_pio_device #(.WAIT_CYCLES(0)) dut_b (
    .clk(clk), .nReset(nReset), .RESETn(RESETn), .DDi(DDi), .DDo(DDo_b), .DDoe(DDoe_b),
    .DA(DA), .CS0n(CS0n), .CS1n(CS1n), .DIORn(DIORn), .DIOWn(DIOWn), .IORDY(IORDY_b),
    .INTRQ(INTRQ_b), .wr_data(wr_data_b), .wr_stb(wr_stb_b), .rd_data(rd_data),
    .rd_stb(rd_stb_b), .cmd_stb(cmd_stb_b), .cmd(cmd_b), .tf_features(feat_b),
    .tf_count(cnt_b), .tf_lba_lo(llo_b), .tf_lba_mid(lmid_b), .tf_lba_hi(lhi_b),
    .tf_device(dev_b), .stat(stat), .err(err), .irq_set(irq_set), .srst(srst_b),
    .state_dbg(st_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  // pulse and IORDY-low counters, sampled away from the active edge
  always @(negedge clk) begin
    if (wr_stb_a)  wr_a++;
    if (wr_stb_b)  wr_b++;
    if (rd_stb_a)  rd_a++;
    if (rd_stb_b)  rd_b++;
    if (cmd_stb_a) cm_a++;
    if (cmd_stb_b) cm_b++;
    if (!IORDY_a)  lo_a++;
    if (!IORDY_b)  lo_b++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic host_write(input logic c0, input logic c1, input logic [2:0] a,
                            input logic [15:0] d);
    CS0n = c0; CS1n = c1; DA = a;
    cyc(2);
    DDi = d; DIOWn = 1'b0;
    cyc(28);
    DIOWn = 1'b1;
    cyc(6);
    CS0n = 1'b1; CS1n = 1'b1; DA = 3'd0; DDi = 16'h0000;
    cyc(2);
  endtask

  task automatic host_read(input logic c0, input logic c1, input logic [2:0] a,
                           output logic [15:0] o_ddo, output logic o_oe);
    CS0n = c0; CS1n = c1; DA = a;
    cyc(2);
    DIORn = 1'b0;
    cyc(20);
    o_ddo = DDo_a; o_oe = DDoe_a;
    cyc(8);
    DIORn = 1'b1;
    cyc(6);
    CS0n = 1'b1; CS1n = 1'b1; DA = 3'd0;
    cyc(2);
  endtask

  task automatic pulse_irq();
    irq_set = 1'b1;
    cyc(1);
    irq_set = 1'b0;
    cyc(1);
  endtask

  initial begin
    logic [15:0] v;
    logic        oe;
    logic        seen;
    int s_wa, s_wb, s_ra, s_rb, s_ca, s_la, s_lb;

    cyc(4);
    chk("rst_ddoe", {15'd0, DDoe_a}, 16'd0);
    chk("rst_ddo", DDo_a, 16'h0000);
    chk("rst_iordy", {15'd0, IORDY_a}, 16'd1);
    chk("rst_intrq", {15'd0, INTRQ_a}, 16'd0);
    chk("rst_cmd", {8'd0, cmd_a}, 16'h0000);
    chk("rst_srst", {15'd0, srst_a}, 16'd0);
    chk("rst_state", {14'd0, st_a}, 16'd0);
    nReset = 1'b1;
    cyc(4);

    // data-port write
    s_wa = wr_a; s_wb = wr_b; s_la = lo_a; s_lb = lo_b;
    host_write(1'b0, 1'b1, 3'd0, 16'hA55A);
    chk("w0_stb_b", 16'(wr_b - s_wb), 16'd1);
    chk("w0_data_b", wr_data_b, 16'hA55A);
    chk("w0_iordy_b", 16'(lo_b - s_lb), 16'd0);
    chk("w4_stb_a", 16'(wr_a - s_wa), 16'd1);
    chk("w4_data_a", wr_data_a, 16'hA55A);
    chk("w4_iordy_a", 16'(lo_a - s_la), 16'd4);

    // data-port read with wait states
    s_ra = rd_a; s_rb = rd_b; s_la = lo_a;
    host_read(1'b0, 1'b1, 3'd0, v, oe);
    chk("r4_ddo", v, 16'h1234);
    chk("r4_ddoe", {15'd0, oe}, 16'd1);
    chk("r4_iordy", 16'(lo_a - s_la), 16'd4);
    chk("r4_rdstb_a", 16'(rd_a - s_ra), 16'd1);
    chk("r0_rdstb_b", 16'(rd_b - s_rb), 16'd1);
    chk("r4_ddoe_after", {15'd0, DDoe_a}, 16'd0);

    // task-file write and readback
    s_wa = wr_a; s_ra = rd_a;
    host_write(1'b0, 1'b1, 3'd2, 16'hC35A);
    chk("cnt_reg", {8'd0, cnt_a}, 16'h005A);
    host_read(1'b0, 1'b1, 3'd2, v, oe);
    chk("cnt_read", v, 16'h005A);
    chk("cnt_read_oe", {15'd0, oe}, 16'd1);
    chk("cnt_no_strobes", 16'((wr_a - s_wa) + (rd_a - s_ra)), 16'd0);
    host_write(1'b0, 1'b1, 3'd1, 16'hBE11);
    chk("feat_reg", {8'd0, feat_a}, 16'h0011);
    host_read(1'b0, 1'b1, 3'd1, v, oe);
    chk("err_read", v, 16'h0004);

    // interrupt handling
    pulse_irq();
    chk("irq_set", {15'd0, INTRQ_a}, 16'd1);
    host_read(1'b1, 1'b0, 3'd6, v, oe);
    chk("alt_read", v, 16'h0050);
    chk("alt_keeps_irq", {15'd0, INTRQ_a}, 16'd1);
    host_read(1'b0, 1'b1, 3'd7, v, oe);
    chk("stat_read", v, 16'h0050);
    chk("stat_clears_irq", {15'd0, INTRQ_a}, 16'd0);
    host_write(1'b1, 1'b0, 3'd6, 16'h0002);
    pulse_irq();
    chk("nien_masks", {15'd0, INTRQ_a}, 16'd0);
    host_write(1'b1, 1'b0, 3'd6, 16'h0000);
    chk("nien_unmask", {15'd0, INTRQ_a}, 16'd1);

    // command write
    s_ca = cm_a;
    host_write(1'b0, 1'b1, 3'd7, 16'h00EC);
    chk("cmd_stb", 16'(cm_a - s_ca), 16'd1);
    chk("cmd_val", {8'd0, cmd_a}, 16'h00EC);
    chk("cmd_clears_irq", {15'd0, INTRQ_a}, 16'd0);

    host_write(1'b0, 1'b1, 3'd3, 16'h0077);
    host_write(1'b1, 1'b0, 3'd6, 16'h0004);
    chk("srst_set", {15'd0, srst_a}, 16'd1);
    chk("llo_set", {8'd0, llo_a}, 16'h0077);

    // bus reset during the wait phase of a read
    s_ra = rd_a;
    CS0n = 1'b0; CS1n = 1'b1; DA = 3'd0;
    cyc(2);
    DIORn = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc(1);
      if (!IORDY_a) seen = 1'b1;
    end
    chk("busrst_wait_seen", {15'd0, seen}, 16'd1);
    RESETn = 1'b0;
    cyc(4);
    chk("busrst_ddoe", {15'd0, DDoe_a}, 16'd0);
    chk("busrst_iordy", {15'd0, IORDY_a}, 16'd1);
    chk("busrst_llo", {8'd0, llo_a}, 16'h0000);
    chk("busrst_cnt", {8'd0, cnt_a}, 16'h0000);
    chk("busrst_feat", {8'd0, feat_a}, 16'h0000);
    chk("busrst_cmd", {8'd0, cmd_a}, 16'h0000);
    chk("busrst_srst_kept", {15'd0, srst_a}, 16'd1);
    DIORn = 1'b1;
    cyc(6);
    RESETn = 1'b1;
    CS0n = 1'b1; CS1n = 1'b1;
    cyc(4);
    chk("busrst_no_rdstb", 16'(rd_a - s_ra), 16'd0);

    // illegal selects and strobes
    s_ra = rd_a; s_wa = wr_a;
    host_read(1'b0, 1'b0, 3'd0, v, oe);
    chk("bothcs_ddoe", {15'd0, oe}, 16'd0);
    CS0n = 1'b0; CS1n = 1'b1; DA = 3'd2;
    DDi = 16'h00FF;
    cyc(2);
    DIORn = 1'b0; DIOWn = 1'b0;
    cyc(20);
    chk("bothstb_ddoe", {15'd0, DDoe_a}, 16'd0);
    chk("bothstb_iordy", {15'd0, IORDY_a}, 16'd1);
    DIORn = 1'b1; DIOWn = 1'b1;
    cyc(6);
    CS0n = 1'b1; CS1n = 1'b1; DDi = 16'h0000;
    cyc(2);
    chk("bothstb_cnt", {8'd0, cnt_a}, 16'h0000);
    host_write(1'b1, 1'b0, 3'd3, 16'h0000);
    chk("unmapped_srst", {15'd0, srst_a}, 16'd1);
    chk("illegal_no_strobes", 16'((rd_a - s_ra) + (wr_a - s_wa)), 16'd0);

    // nReset in the middle of a read
    s_ra = rd_a;
    CS0n = 1'b0; CS1n = 1'b1; DA = 3'd0;
    cyc(2);
    DIORn = 1'b0;
    cyc(12);
    chk("nrst_pre_ddoe", {15'd0, DDoe_a}, 16'd1);
    nReset = 1'b0;
    #1;
    chk("nrst_ddoe", {15'd0, DDoe_a}, 16'd0);
    chk("nrst_srst", {15'd0, srst_a}, 16'd0);
    DIORn = 1'b1;
    cyc(4);
    nReset = 1'b1;
    CS0n = 1'b1; CS1n = 1'b1;
    cyc(4);
    chk("nrst_no_rdstb", 16'(rd_a - s_ra), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ata_pio_device.md
ATA_PIO_DEVICE -- requirements
Module: ata_pio_device

Interface
REQ-001 Parameter WAIT_CYCLES, default 0: clk cycles IORDY is held low at the start of each data-port access; 0 means IORDY is never deasserted.
REQ-002 clk  input  1  master clock; all logic on its rising edge.
REQ-003 nReset  input  1  reset, asynchronous, active-low.
REQ-004 RESETn  input  1  ATA bus hardware reset from host, active-low, asynchronous to clk.
REQ-005 DDi  input  16  ATA data bus from host.
REQ-006 DDo  output  16  ATA data bus to host.
REQ-007 DDoe  output  1  DDo output enable, 1 = drive bus.
REQ-008 DA  input  3  ATA register address.
REQ-009 CS0n, CS1n  input  1 each  ATA command-block / control-block selects, active-low.
REQ-010 DIORn, DIOWn  input  1 each  ATA read / write strobes, active-low.
REQ-011 IORDY  output  1  ATA ready, 0 = host must extend strobe.
REQ-012 INTRQ  output  1  ATA interrupt request, active-high.
REQ-013 wr_data  output  16  word written by host to data port; valid with wr_stb.
REQ-014 wr_stb  output  1  one-clk pulse, host data-port write completed.
REQ-015 rd_data  input  16  word returned on host data-port reads.
REQ-016 rd_stb  output  1  one-clk pulse, host data-port read completed; local side advances rd_data.
REQ-017 cmd_stb  output  1  one-clk pulse, host wrote Command register; cmd carries value.
REQ-018 cmd  output  8  last Command byte written.
REQ-019 tf_features, tf_count, tf_lba_lo, tf_lba_mid, tf_lba_hi, tf_device  output  8 each  task-file register contents.
REQ-020 stat, err  input  8 each  Status and Error values supplied by local side.
REQ-021 irq_set  input  1  one-clk pulse, set interrupt pending.
REQ-022 srst  output  1  Device Control SRST bit (level).

Function
REQ-030 DIORn, DIOWn, CS0n, CS1n, DA, RESETn SHALL each pass a 2-flop synchronizer; all decoding uses synchronized values.
REQ-031 Access start SHALL be a synchronized 1->0 transition of exactly one strobe; both strobes low simultaneously SHALL be ignored (no access, DDoe 0).
REQ-032 Address decode latched at access start: CS0n=0,CS1n=1 -> command block DA 0..7; CS0n=1,CS1n=0,DA=6 -> Alternate Status (R) / Device Control (W); any other combination -> unmapped: reads do not drive bus, writes discarded.
REQ-033 Command block map: 0 data(16-bit); 1 Error(R)/Features(W); 2 Count; 3 LBA low; 4 LBA mid; 5 LBA high; 6 Device; 7 Status(R)/Command(W).
REQ-034 FSM states IDLE, WAIT, ACTIVE. IDLE -> WAIT on access start to data port when WAIT_CYCLES>0, else -> ACTIVE. WAIT -> ACTIVE after WAIT_CYCLES clks. ACTIVE -> IDLE on synchronized strobe 0->1.
REQ-035 IORDY SHALL be 0 exactly while in WAIT, 1 otherwise.
REQ-036 Strobe release while in WAIT SHALL return FSM to IDLE with no strobe pulses and no register update.
REQ-037 Reads: DDoe SHALL be 1 in WAIT and ACTIVE of a mapped read; DDo = rd_data (data port), {8'h00, reg} for 8-bit registers; DDoe SHALL fall on the clk the strobe release is detected.
REQ-038 Writes: DDi SHALL be registered every clk while in ACTIVE; on release, committed value = last registered sample; 8-bit registers take DDi[7:0].
REQ-039 On read release of data port: rd_stb pulse 1 clk. On write release of data port: wr_stb pulse 1 clk with wr_data.
REQ-040 Command write: cmd updated, cmd_stb pulse 1 clk, interrupt pending cleared.
REQ-041 Device Control write: nIEN = DDi[1], srst = DDi[2].
REQ-042 INTRQ SHALL equal pending & !nIEN; irq_set sets pending; Status (addr 7) read release clears pending; Alternate Status read SHALL NOT clear it; irq_set coinciding with clear -> pending set.
REQ-043 Synchronized RESETn=0 SHALL abort any access (FSM IDLE, DDoe 0, IORDY 1, no strobes) and clear task file, cmd, pending, nIEN; srst unaffected.

Reset
REQ-050 nReset=0 SHALL asynchronously force: FSM IDLE, DDo 0, DDoe 0, IORDY 1, INTRQ 0, wr_stb/rd_stb/cmd_stb 0, wr_data 0, cmd 0, all tf_* 0, srst 0, nIEN 0, pending 0, synchronizers to inactive (strobes/CS/RESETn 1).
REQ-051 nReset asserted mid-access SHALL release the bus within the same cycle (DDoe 0) with no strobe pulse.

Verification
REQ-060 WAIT_CYCLES=0; host writes 16'hA55A to CS0 DA0 (T2=28 clk) -> one wr_stb, wr_data=16'hA55A, IORDY stays 1.
REQ-061 WAIT_CYCLES=4; host reads data port, rd_data=16'h1234 -> IORDY low exactly 4 clk, DDo=16'h1234 with DDoe 1, one rd_stb after release.
REQ-062 Write 8'h5A to Count, read back -> DDo=16'h005A; tf_count=8'h5A.
REQ-063 irq_set, then Alternate Status read -> INTRQ stays 1; Status read -> INTRQ 0 after release; Device Control write 8'h02 then irq_set -> INTRQ 0.
REQ-064 Command write 8'hEC -> cmd_stb single pulse, cmd=8'hEC; with pending set, INTRQ clears.
REQ-065 RESETn low during WAIT of a read -> DDoe 0, IORDY 1, no rd_stb, tf_* 0; CS0n and CS1n both low, or both strobes low -> no bus drive, no strobes.
